// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm keypad front end: key codes, FSM states
// and the HH:MM validity rule.
package alarm_pkg;

  localparam logic [3:0] KEY_ALARM = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam int unsigned TMO_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // Accepts 00:00 .. 23:59
  function automatic logic is_valid_hhmm(input logic [3:0] ms_hr,
                                         input logic [3:0] ls_hr,
                                         input logic [3:0] ms_min,
                                         input logic [3:0] ls_min);
    logic hr_ok;
    hr_ok = ((ms_hr < 4'd2) && (ls_hr <= 4'd9)) ||
            ((ms_hr == 4'd2) && (ls_hr <= 4'd3));
    return hr_ok && (ms_min <= 4'd5) && (ls_min <= 4'd9);
  endfunction

endpackage

// File: rtl/alarm_key_entry_if.sv
// Keypad-side inputs and alarm-register-side outputs of alarm_key_entry.
interface alarm_key_entry_if;

  logic [3:0] key;
  logic       key_valid;
  logic       one_second;
  logic [3:0] new_alarm_ms_hr;
  logic [3:0] new_alarm_ls_hr;
  logic [3:0] new_alarm_ms_min;
  logic [3:0] new_alarm_ls_min;
  logic       load_new_alarm;
  logic       entry_active;
  logic       entry_error;

  modport master (
    output key, key_valid, one_second,
    input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    input  load_new_alarm, entry_active, entry_error
  );

  modport slave (
    input  key, key_valid, one_second,
    output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    output load_new_alarm, entry_active, entry_error
  );

endinterface

// File: rtl/entry_timeout_ctr.sv
// Tick counter with synchronous clear; term_o pulses on the tick that would
// reach TIMEOUT_SECS, and the counter wraps to zero on that tick.
module entry_timeout_ctr
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_SECS = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [TMO_W-1:0] TERM_CNT = TMO_W'(TIMEOUT_SECS - 1);

  logic [TMO_W-1:0] cnt_q;

  // Clear has priority, so a key arriving with a tick never times out.
  assign term_o = en_i && !clr_i && (cnt_q == TERM_CNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || term_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_key_entry.sv
// Keypad entry of an HH:MM alarm time into a 4-digit shift buffer, validated
// on the ALARM key; abandoned entries time out on one-second ticks.
module alarm_key_entry
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_SECS = 10
) (
  input logic              clock,
  input logic              reset,
  alarm_key_entry_if.slave bus
);

  state_t     state_q;
  logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
  logic [2:0] cnt_q;
  logic       load_q, act_q, err_q;

  logic key_digit, key_alarm, key_clear, key_accepted;
  logic tmo_clr, tmo_en, tmo_term;

  assign key_digit    = bus.key_valid && is_digit(bus.key);
  assign key_alarm    = bus.key_valid && (bus.key == KEY_ALARM);
  assign key_clear    = bus.key_valid && (bus.key == KEY_CLEAR);
  assign key_accepted = key_digit || key_alarm || key_clear;

  assign tmo_clr = (state_q != ST_ENTRY) || key_accepted;
  assign tmo_en  = (state_q == ST_ENTRY) && bus.one_second;

  entry_timeout_ctr #(
    .TIMEOUT_SECS(TIMEOUT_SECS)
  ) u_tmo (
    .clk_i (clock),
    .rst_ni(reset),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .term_o(tmo_term)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ms_hr_q  <= '0;
      ls_hr_q  <= '0;
      ms_min_q <= '0;
      ls_min_q <= '0;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      act_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (key_digit) begin
            ms_hr_q  <= '0;
            ls_hr_q  <= '0;
            ms_min_q <= '0;
            ls_min_q <= bus.key;
            cnt_q    <= 3'd1;
            state_q  <= ST_ENTRY;
            act_q    <= 1'b1;
          end
        end
        ST_ENTRY: begin
          if (key_digit) begin
            ms_hr_q  <= ls_hr_q;
            ls_hr_q  <= ms_min_q;
            ms_min_q <= ls_min_q;
            ls_min_q <= bus.key;
            cnt_q    <= (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
          end else if (key_alarm &&
                       (cnt_q == 3'd4) &&
                       is_valid_hhmm(ms_hr_q, ls_hr_q, ms_min_q, ls_min_q)) begin
            load_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            act_q   <= 1'b0;
          end else if (key_alarm || key_clear || tmo_term) begin
            err_q    <= key_alarm;
            ms_hr_q  <= '0;
            ls_hr_q  <= '0;
            ms_min_q <= '0;
            ls_min_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            act_q    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.new_alarm_ms_hr  = ms_hr_q;
  assign bus.new_alarm_ls_hr  = ls_hr_q;
  assign bus.new_alarm_ms_min = ms_min_q;
  assign bus.new_alarm_ls_min = ls_min_q;
  assign bus.load_new_alarm   = load_q;
  assign bus.entry_active     = act_q;
  assign bus.entry_error      = err_q;

endmodule

// File: tb/tb_alarm_key_entry.sv
// Bench for alarm_key_entry: directed vector table, reset corner cases, and
// random stimulus against an arithmetic reference model.
module tb_alarm_key_entry;

  localparam int unsigned TO = 3;

  typedef struct {
    logic [3:0]  key;
    logic        kv;
    logic        tick;
    logic [15:0] digits;
    logic        load;
    logic        act;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alarm_key_entry_if bus ();

  alarm_key_entry #(
    .TIMEOUT_SECS(TO)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int pass_cnt = 0;
  int total    = 0;

  // Reference model: the buffer is kept as a decimal number 0..9999.
  int m_val = 0, m_cnt = 0, m_secs = 0;
  bit m_act = 0, m_load = 0, m_err = 0;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] k, input logic kv, input logic tk,
                              input logic [15:0] d, input logic l, input logic a,
                              input logic e);
    vec_t v;
    v.key = k; v.kv = kv; v.tick = tk; v.digits = d; v.load = l; v.act = a; v.err = e;
    return v;
  endfunction

  function automatic logic [18:0] got_vec();
    return {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min,
            bus.new_alarm_ls_min, bus.load_new_alarm, bus.entry_active, bus.entry_error};
  endfunction

  task automatic check(input string name, input logic [18:0] exp);
    logic [18:0] got;
    got = got_vec();
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got digits=%h load/act/err=%b required digits=%h load/act/err=%b",
                  name, got[18:3], got[2:0], exp[18:3], exp[2:0]);
  endtask

  task automatic apply(input logic [3:0] k, input logic kv, input logic tk);
    bus.key = k; bus.key_valid = kv; bus.one_second = tk;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0; bus.one_second = 1'b0;
  endtask

  task automatic model_step(input int k, input bit kv, input bit tk);
    m_load = 0; m_err = 0;
    if (!m_act) begin
      if (kv && k <= 9) begin m_val = k; m_cnt = 1; m_act = 1; m_secs = 0; end
    end else if (kv && k <= 9) begin
      m_val = (m_val * 10 + k) % 10000;
      m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      m_secs = 0;
    end else if (kv && k == 10) begin
      if (m_cnt == 4 && m_val / 100 <= 23 && m_val % 100 <= 59) m_load = 1;
      else begin m_err = 1; m_val = 0; end
      m_cnt = 0; m_act = 0; m_secs = 0;
    end else if (kv && k == 12) begin
      m_val = 0; m_cnt = 0; m_act = 0; m_secs = 0;
    end else if (tk) begin
      m_secs++;
      if (m_secs == TO) begin m_val = 0; m_cnt = 0; m_act = 0; m_secs = 0; end
    end
  endtask

  function automatic logic [18:0] model_vec();
    logic [15:0] d;
    d = {4'(m_val / 1000), 4'((m_val / 100) % 10), 4'((m_val / 10) % 10), 4'(m_val % 10)};
    return {d, m_load, m_act, m_err};
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.key = '0; bus.key_valid = 1'b0; bus.one_second = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset", '0);
    @(negedge clk) rst_n = 1'b1;

    // key, kv, tick, expected digits, load, active, error
    vecs.push_back(mk(4'd0, 1, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(4'd7, 1, 0, 16'h0007, 0, 1, 0));
    vecs.push_back(mk(4'd3, 1, 0, 16'h0073, 0, 1, 0));
    vecs.push_back(mk(4'd0, 1, 0, 16'h0730, 0, 1, 0));
    vecs.push_back(mk(4'hA, 1, 0, 16'h0730, 1, 0, 0));
    vecs.push_back(mk(4'd0, 0, 0, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(4'd2, 1, 0, 16'h0002, 0, 1, 0));
    vecs.push_back(mk(4'd4, 1, 0, 16'h0024, 0, 1, 0));
    vecs.push_back(mk(4'd0, 1, 0, 16'h0240, 0, 1, 0));
    vecs.push_back(mk(4'd0, 1, 0, 16'h2400, 0, 1, 0));
    vecs.push_back(mk(4'hA, 1, 0, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(4'd0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(4'd1, 1, 0, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(4'd2, 1, 0, 16'h0012, 0, 1, 0));
    vecs.push_back(mk(4'hA, 1, 0, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(4'd1, 1, 0, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(4'd2, 1, 0, 16'h0012, 0, 1, 0));
    vecs.push_back(mk(4'd3, 1, 0, 16'h0123, 0, 1, 0));
    vecs.push_back(mk(4'd4, 1, 0, 16'h1234, 0, 1, 0));
    vecs.push_back(mk(4'd5, 1, 0, 16'h2345, 0, 1, 0));
    vecs.push_back(mk(4'hA, 1, 0, 16'h2345, 1, 0, 0));
    vecs.push_back(mk(4'hA, 1, 0, 16'h2345, 0, 0, 0));
    vecs.push_back(mk(4'hC, 1, 0, 16'h2345, 0, 0, 0));
    vecs.push_back(mk(4'd1, 1, 0, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(4'd9, 1, 0, 16'h0019, 0, 1, 0));
    vecs.push_back(mk(4'd6, 1, 0, 16'h0196, 0, 1, 0));
    vecs.push_back(mk(4'd0, 1, 0, 16'h1960, 0, 1, 0));
    vecs.push_back(mk(4'hA, 1, 0, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(4'd9, 1, 0, 16'h0009, 0, 1, 0));
    vecs.push_back(mk(4'hE, 1, 0, 16'h0009, 0, 1, 0));
    vecs.push_back(mk(4'hC, 1, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(4'd1, 1, 0, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(4'd1, 1, 0, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(4'd5, 1, 1, 16'h0015, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0015, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0015, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(4'd7, 1, 0, 16'h0007, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0007, 0, 1, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0007, 0, 1, 0));
    vecs.push_back(mk(4'hE, 1, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(4'd0, 0, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(4'd2, 1, 0, 16'h0002, 0, 1, 0));
    vecs.push_back(mk(4'd3, 1, 0, 16'h0023, 0, 1, 0));
    vecs.push_back(mk(4'd5, 1, 0, 16'h0235, 0, 1, 0));
    vecs.push_back(mk(4'd9, 1, 0, 16'h2359, 0, 1, 0));
    vecs.push_back(mk(4'hA, 1, 0, 16'h2359, 1, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].key, vecs[i].kv, vecs[i].tick);
      check($sformatf("vec%0d", i), {vecs[i].digits, vecs[i].load, vecs[i].act, vecs[i].err});
    end

    // Asynchronous reset in the middle of an entry.
    @(negedge clk);
    apply(4'd1, 1, 0);
    apply(4'd2, 1, 0);
    @(negedge clk) rst_n = 1'b0;
    #1 check("rst_mid_entry", '0);
    @(negedge clk) rst_n = 1'b1;
    apply(4'd0, 0, 0);
    check("rst_release", '0);

    // Reset held across the ALARM edge drops the pending load strobe.
    apply(4'd1, 1, 0);
    apply(4'd2, 1, 0);
    apply(4'd3, 1, 0);
    apply(4'd0, 1, 0);
    @(negedge clk);
    bus.key = 4'hA; bus.key_valid = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 check("rst_drops_strobe", '0);
    bus.key_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    apply(4'd0, 0, 0);
    check("rst_no_late_strobe", '0);

    // Random traffic against the model, starting from the reset state.
    for (int n = 0; n < 1500; n++) begin
      int k;
      bit kv, tk;
      k  = int'($urandom_range(0, 15));
      kv = ($urandom_range(0, 1) == 1);
      tk = ($urandom_range(0, 7) == 0);
      apply(4'(k), kv, tk);
      model_step(k, kv, tk);
      check($sformatf("rand%0d", n), model_vec());
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
